// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory responder: RISC-V
//                load/store funct3 codes and the responder FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // RISC-V load/store size and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Combinational lane logic for byte/half/word accesses.
//                Produces the store byte-enable mask and lane-replicated
//                store word, the extended load value, and the misalignment
//                and illegal-encoding flags.
//  Ports       : write    - 1 = store, 0 = load
//                funct3   - size/sign code
//                addr_lo  - byte offset within the word
//                wdata    - right-aligned store data
//                rword    - full word read from the array
//                byte_en  - per-byte write enables
//                wword    - store data replicated into every candidate lane
//                rdata    - extended load result
//                misalign - access not naturally aligned
//                illegal  - unsupported funct3 for this access kind
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_align
  import dmem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] w_shifted;
  logic [15:0] w_half;

  // Byte lane is simply the word shifted down by the byte offset
  assign w_shifted = rword >> {addr_lo, 3'b000};
  assign w_half    = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en = 4'b0000;
    wword   = wdata;
    case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wword   = wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wword   = wdata;
      end
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (funct3)
      F3_B:    rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    rdata = {{16{w_half[15]}}, w_half};
      F3_W:    rdata = rword;
      F3_BU:   rdata = {24'd0, w_shifted[7:0]};
      F3_HU:   rdata = {16'd0, w_half};
      default: rdata = 32'd0;
    endcase
  end

  assign misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

  // Unsigned variants only exist for loads
  assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (write && ((funct3 == F3_BU) || (funct3 == F3_HU)));

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder with a valid/ready
//                request and response handshake. One request is in flight
//                at a time; the array is read/written on the edge that
//                enters RESP and the response is held until consumed.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req_valid/req_ready - request handshake
//                req_write, req_funct3, req_addr, req_wdata - request fields
//                resp_valid/resp_ready - response handshake
//                resp_rdata, resp_err  - response payload
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_enter_resp;

  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_write;
  logic [2:0]  w_funct3;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_rword;
  logic [3:0]      w_be;
  logic [31:0]     w_wword;
  logic [31:0]     w_ld_data;
  logic            w_misalign;
  logic            w_illegal;
  logic            w_range_err;
  logic            w_err;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_LAT_M1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // ---------------------------------------------------------------- request latch
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // With LATENCY = 0 the array is accessed on the acceptance edge itself,
  // so the live request must be used while still in IDLE.
  assign w_write  = req_ready ? req_write  : r_write;
  assign w_funct3 = req_ready ? req_funct3 : r_funct3;
  assign w_addr   = req_ready ? req_addr   : r_addr;
  assign w_wdata  = req_ready ? req_wdata  : r_wdata;

  // ---------------------------------------------------------------- access
  assign w_idx       = w_addr[c_AW+1:2];
  assign w_rword     = r_mem[w_idx];
  assign w_range_err = ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
  assign w_err       = w_misalign | w_illegal | w_range_err;

  mem_align u_align (
    .write    (w_write),
    .funct3   (w_funct3),
    .addr_lo  (w_addr[1:0]),
    .wdata    (w_wdata),
    .rword    (w_rword),
    .byte_en  (w_be),
    .wword    (w_wword),
    .rdata    (w_ld_data),
    .misalign (w_misalign),
    .illegal  (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_err || w_write) ? 32'd0 : w_ld_data;
      r_err   <= w_err;
    end
  end

  // Array contents survive reset; only the commit is gated by it
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && w_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder
//                (DEPTH = 256, LATENCY = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int tests;
  int failed;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: present at a falling edge, measure latency,
  // check payload, optionally stall the response, then consume it.
  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int hold);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    // Inputs scrambled after acceptance must not matter
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hDEAD_BEEF;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(LATENCY + 1));
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, ".hold_rdata"}, resp_rdata, exp_rd);
      check({tag, ".hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ".done_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ".done_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    tests      = 0;
    failed     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_err", {31'd0, resp_err}, 32'd0);

    do_req("sw64",   1'b1, 3'b010, 32'h64, 32'h19,       32'h0,        1'b0, 0);
    do_req("lw64",   1'b0, 3'b010, 32'h64, 32'h0,        32'h19,       1'b0, 0);

    do_req("sw80",   1'b1, 3'b010, 32'h80, 32'h11223344, 32'h0,        1'b0, 0);
    do_req("sb81",   1'b1, 3'b000, 32'h81, 32'hAB,       32'h0,        1'b0, 0);
    do_req("lb81",   1'b0, 3'b000, 32'h81, 32'h0,        32'hFFFFFFAB, 1'b0, 0);
    do_req("lbu81",  1'b0, 3'b100, 32'h81, 32'h0,        32'h000000AB, 1'b0, 0);
    do_req("lw80",   1'b0, 3'b010, 32'h80, 32'h0,        32'h1122AB44, 1'b0, 0);

    do_req("sh82",   1'b1, 3'b001, 32'h82, 32'h8001,     32'h0,        1'b0, 0);
    do_req("lh82",   1'b0, 3'b001, 32'h82, 32'h0,        32'hFFFF8001, 1'b0, 0);
    do_req("lhu82",  1'b0, 3'b101, 32'h82, 32'h0,        32'h00008001, 1'b0, 0);
    do_req("lh83",   1'b0, 3'b001, 32'h83, 32'h0,        32'h0,        1'b1, 0);
    do_req("lb83",   1'b0, 3'b000, 32'h83, 32'h0,        32'hFFFFFF80, 1'b0, 0);

    // Stalled response: payload and handshake held for 5 cycles
    do_req("lw80h",  1'b0, 3'b010, 32'h80, 32'h0,        32'h8001AB44, 1'b0, 5);

    // Out-of-range store leaves the array alone
    do_req("sw0",    1'b1, 3'b010, 32'h0,   32'hCAFEF00D, 32'h0,       1'b0, 0);
    do_req("sw400",  1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0,       1'b1, 0);
    do_req("lw0",    1'b0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0, 0);

    // Last in-range word and other error encodings
    do_req("sw3fc",  1'b1, 3'b010, 32'h3FC, 32'hA5A5_0F0F, 32'h0,       1'b0, 0);
    do_req("lw3fc",  1'b0, 3'b010, 32'h3FC, 32'h0,        32'hA5A50F0F, 1'b0, 0);
    do_req("lw66",   1'b0, 3'b010, 32'h66,  32'h0,        32'h0,        1'b1, 0);
    do_req("sbu",    1'b1, 3'b100, 32'h64,  32'h77,       32'h0,        1'b1, 0);
    do_req("ld011",  1'b0, 3'b011, 32'h64,  32'h0,        32'h0,        1'b1, 0);
    do_req("lw64b",  1'b0, 3'b010, 32'h64,  32'h0,        32'h19,       1'b0, 0);

    // Reset during WAIT aborts the store
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h64;
    req_wdata  = 32'h5;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort.req_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort.no_resp", 32'(seen), 32'd0);
    do_req("lw64c",  1'b0, 3'b010, 32'h64,  32'h0,        32'h19,       1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the array.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (0..15 legal).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder accepts the request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: RISC-V funct3 size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned (the LSBs hold the byte or halfword).
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a response is present.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the core consumes the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load data, sign- or zero-extended; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit: the request was misaligned, illegal, or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; acceptance occurs when req_valid & req_ready.
REQ-017 On acceptance, the block SHALL latch write, funct3, addr and wdata, and go to WAIT with counter = LATENCY-1; if LATENCY = 0 it SHALL go directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-019 resp_valid SHALL rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 Array access SHALL occur on the edge entering RESP: a store commits there, and load data is registered into resp_rdata there.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready = 1.
REQ-022 When resp_ready = 1 in RESP, the FSM SHALL go to IDLE on that edge, with no same-cycle new acceptance; maximum throughput is one request per LATENCY+2 cycles.
REQ-023 A store SHALL set byte-lane enables for sb = addr[1:0], sh = {addr[1],0} pair, sw = all four, and SHALL place wdata into the selected lanes; other bytes are unchanged.
REQ-024 A load SHALL select its lane(s) by addr[1:0]; lb/lh SHALL sign-extend, lbu/lhu SHALL zero-extend, and lw SHALL pass through.
REQ-025 The block SHALL raise error when any of the following holds:
- half access with addr[0] = 1;
- word access with addr[1:0] != 0;
- funct3 is 011, 110 or 111;
- store funct3 is 100 or 101;
- addr[31:2] >= DEPTH.
REQ-026 An error SHALL suppress the write, force resp_rdata = 0, and set resp_err = 1; latency is unchanged.
REQ-027 Input changes while the FSM is not in IDLE SHALL be ignored, because requests are used only from the latched copy.

Reset
REQ-028 While reset = 1 on a clock edge, the block SHALL set: FSM = IDLE, counter = 0, req_ready = 1 (from the first cycle after reset), resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction: no store commits on or after the reset edge, and the pending response is discarded.
REQ-030 Reset SHALL NOT clear array contents.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum typedef (IDLE/WAIT/RESP).
REQ-032 One combinational sub-module, mem_align, SHALL compute the byte-enable mask, the aligned write word, load extension, and the misalignment/illegal flags.
REQ-033 The array SHALL be a DEPTH x 32 register array with a per-byte write.

Verification
REQ-034 Scenario (LATENCY = 2): sw addr 0x64, data 0x19 at cycle 0 -> resp_valid at cycle 3 with resp_err = 0; a following lw 0x64 returns 0x00000019.
REQ-035 Scenario: sw 0x80 = 0x11223344; sb 0x81 = 0xAB; lb 0x81 -> 0xFFFFFFAB; lbu 0x81 -> 0x000000AB; lw 0x80 -> 0x1122AB44.
REQ-036 Scenario: sh 0x82 = 0x8001; lh 0x82 -> 0xFFFF8001; lhu 0x82 -> 0x00008001; lh 0x83 -> resp_err = 1, resp_rdata = 0.
REQ-037 Scenario: resp_ready is held 0 for 5 cycles in RESP -> resp_valid and resp_rdata are stable throughout, and req_ready = 0 throughout.
REQ-038 Scenario: sw 0x400 (DEPTH = 256) -> resp_err = 1, and the array is unchanged (lw 0x0 unchanged).
REQ-039 Scenario: reset is pulsed during WAIT of sw 0x64 = 0x5 -> resp_valid is never asserted, lw 0x64 returns the old value, and req_ready = 1 in the cycle after reset.
